// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
// UART_TX_PARITY_EN adds the transmitter PARITY state.
package uart_pkg;

  localparam int unsigned OS_TICKS = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/tx_tick_counter.sv
// 6-bit baud-tick counter with synchronous clear and tick enable.
// Clear has priority over the tick; tc_o compares the current count.
module tx_tick_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       tick_i,
  input  logic [5:0] tc_val_i,
  output logic       tc_o
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_BIT data bits LSB first, stop of SB_TICK ticks.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned D_BIT   = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int unsigned NW      = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);
  localparam logic [5:0]    BIT_TC  = 6'(OS_TICKS - 1);
  localparam logic [5:0]    STOP_TC = 6'(SB_TICK - 1);

  uart_tx_state_t   state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [D_BIT-1:0] b_q, b_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [5:0]       tc_val;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign tc_val = (state_q == TX_STOP) ? STOP_TC : BIT_TC;

  tx_tick_counter u_tick_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (cnt_clr),
    .tick_i   (cnt_en),
    .tc_val_i (tc_val),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        // A tick coinciding with the start strobe is dropped by the clear.
        if (tx_start) begin
          b_d     = din;
          cnt_clr = 1'b1;
          state_d = TX_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            n_d     = '0;
            state_d = TX_DATA;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      TX_DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            b_d     = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = TX_PARITY;
`else
              state_d = TX_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = TX_STOP;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`endif
      TX_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != TX_IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default 8N1 instance plus a SB_TICK=32 instance.
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB        = 11;
  localparam int EXP_TICKS = 176;
  localparam int EXP_CYC32 = 192;
`else
  localparam int NB        = 10;
  localparam int EXP_TICKS = 160;
  localparam int EXP_CYC32 = 176;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = '0;
  logic       tx, tx_busy, tx_done_tick;

  logic       tick32 = 1'b1;
  logic       start32 = 1'b0;
  logic [7:0] din32 = '0;
  logic       tx32, busy32, done32;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int tick_base = 0;
  int tick_div = 0;

  uart_tx u_dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_tx #(.D_BIT(8), .SB_TICK(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (tick32),
    .tx_start     (start32),
    .din          (din32),
    .tx           (tx32),
    .tx_busy      (busy32),
    .tx_done_tick (done32)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    s_tick   <= (tick_div == 3);
  end

  // Ticks consumed by a frame in progress.
  always @(posedge clk) begin
    if (tx_busy && s_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] data, input string tag);
    din      = data;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tick_base = tick_cnt;
    chk({tag, "_busy_rise"}, 32'(tx_busy), 32'd1);
    chk({tag, "_tx_still_high"}, 32'(tx), 32'd1);
    step();
    chk({tag, "_start_low"}, 32'(tx), 32'd0);
  endtask

  // Entered one sample after the start-bit fall; returns in the done cycle.
  task automatic body(input logic [7:0] data, input bit inject, input string tag);
    logic [10:0] exp;
    int          pre_done;
    bit          got;
    exp      = '1;
    exp[0]   = 1'b0;
    for (int i = 0; i < 8; i++) exp[1+i] = data[i];
`ifdef UART_TX_PARITY_EN
    exp[9]   = ^data;
`endif
    pre_done = 0;
    got      = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < ((k == 0) ? 32 : 64); c++) begin
        if (inject && k == 4 && c == 10) begin
          din      = 8'hFF;
          tx_start = 1'b1;
        end
        step();
        tx_start = 1'b0;
        if (tx_done_tick) pre_done++;
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(tx), 32'(exp[k]));
    end
    for (int c = 0; c < 200; c++) begin
      step();
      if (tx_done_tick) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_done_tx"}, 32'(tx), 32'd1);
    chk({tag, "_early_done"}, 32'(pre_done), 32'd0);
    chk({tag, "_ticks"}, 32'(tick_cnt - tick_base), 32'(EXP_TICKS));
  endtask

  initial begin
    int cyc;
    int high;
    bit seen_low;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done_tick), 32'd0);
    chk("rst_tx32", 32'(tx32), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    accept(8'h55, "f55");
    body(8'h55, 1'b0, "f55");
    step();
    chk("f55_pulse_one_cycle", 32'(tx_done_tick), 32'd0);

    accept(8'hA5, "fA5");
    body(8'hA5, 1'b0, "fA5");
    step();

    accept(8'h00, "f00");
    body(8'h00, 1'b1, "f00");
    step();
    chk("f00_single_done", 32'(tx_done_tick), 32'd0);
    repeat (70) step();
    chk("f00_no_second_frame", 32'(tx_busy), 32'd0);

    accept(8'h0F, "f0F");
    body(8'h0F, 1'b0, "f0F");
    accept(8'h3C, "b2b3C");
    body(8'h3C, 1'b0, "b2b3C");
    step();

    accept(8'h81, "r81");
    repeat (100) step();
    rst = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_done", 32'(tx_done_tick), 32'd0);
    step();
    step();
    chk("midrst_no_done", 32'(tx_done_tick), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    accept(8'h81, "f81");
    body(8'h81, 1'b0, "f81");
    step();

    din32   = 8'h00;
    start32 = 1'b1;
    step();
    start32 = 1'b0;
    chk("sb32_busy_rise", 32'(busy32), 32'd1);
    cyc      = 0;
    high     = 0;
    seen_low = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step();
      cyc = i;
      if (tx32 == 1'b0) seen_low = 1'b1;
      else if (seen_low) high++;
      if (done32) break;
    end
    chk("sb32_done_seen", 32'(done32), 32'd1);
    chk("sb32_done_cycle", 32'(cyc), 32'(EXP_CYC32));
`ifdef UART_TX_PARITY_EN
    chk("sb32_stop_len", 32'(high), 32'd32 + 32'd16 * 32'(^din32 == 1'b1));
`else
    chk("sb32_stop_len", 32'(high), 32'd32);
`endif
    chk("sb32_done_busy", 32'(busy32), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
